// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
// Optional dimming is enabled by defining SEG_SCAN_DIM_EN.
package seg_scan_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    typedef enum logic {
        BLANK,
        SHOW
    } state_t;

    function automatic logic [7:0] an_onehot_n(input logic [2:0] idx);
        return ~(8'd1 << idx);
    endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Digit-code inputs and scanned pin outputs of the segment scanner.
// The dim input exists only when SEG_SCAN_DIM_EN is defined.
interface seg_scan_if;

    logic            en;
    logic [7:0][7:0] seg;
`ifdef SEG_SCAN_DIM_EN
    logic [2:0]      dim;
`endif
    logic [7:0]      scan_seg;
    logic [7:0]      scan_an;
    logic            frame_start;

`ifdef SEG_SCAN_DIM_EN
    modport master (
        output en, seg, dim,
        input  scan_seg, scan_an, frame_start
    );
    modport slave (
        input  en, seg, dim,
        output scan_seg, scan_an, frame_start
    );
`else
    modport master (
        output en, seg,
        input  scan_seg, scan_an, frame_start
    );
    modport slave (
        input  en, seg,
        output scan_seg, scan_an, frame_start
    );
`endif

endinterface

// File: rtl/seg_scan_timer.sv
// Slot counter and digit index for the scanner; exposes next-cycle values
// so the output registers line up with the counter of the same cycle.
module seg_scan_timer
    import seg_scan_pkg::*;
#(
    parameter int DIGITS    = 8,
    parameter int TICK_DIV  = 1000,
    parameter int BLANK_CYC = 16,
    parameter int CW        = $clog2(TICK_DIV)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_en,
    output logic          o_slot_last,
    output logic          o_frame_first,
    output state_t        o_state,
    output logic [CW-1:0] o_cnt_nxt,
    output logic [2:0]    o_idx_nxt,
    output state_t        o_state_nxt
);

    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_BL   = CW'(BLANK_CYC);
    localparam logic [2:0]    IDX_LAST = 3'(DIGITS - 1);

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    state_t        r_state;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_idx_nxt;
    state_t        w_state_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= BLANK;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_cnt_nxt   = r_cnt + CW'(1);
        w_idx_nxt   = r_idx;
        w_state_nxt = BLANK;
        if (!i_en) begin
            w_cnt_nxt = '0;
            w_idx_nxt = '0;
        end else begin
            if (r_cnt == CNT_LAST) begin
                w_cnt_nxt = '0;
                w_idx_nxt = (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
            end
            w_state_nxt = (w_cnt_nxt >= CNT_BL) ? SHOW : BLANK;
        end
    end

    always_comb begin
        o_slot_last   = (r_cnt == CNT_LAST);
        o_frame_first = (r_cnt == '0) && (r_idx == '0);
        o_state       = r_state;
        o_cnt_nxt     = w_cnt_nxt;
        o_idx_nxt     = w_idx_nxt;
        o_state_nxt   = w_state_nxt;
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexes eight latched digit codes onto one segment bus.
// Define SEG_SCAN_DIM_EN to add the per-frame dim input.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int DIGITS    = 8,
    parameter int TICK_DIV  = 1000,
    parameter int BLANK_CYC = 16
) (
    input logic       clock,
    input logic       reset,
    seg_scan_if.slave bus
);

    localparam int CW       = $clog2(TICK_DIV);
    localparam int SHOW_LEN = TICK_DIV - BLANK_CYC;

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("seg_scan_mux: DIGITS must be 1..8");
    end
    if (TICK_DIV < 2) begin : g_bad_div
        $error("seg_scan_mux: TICK_DIV must be >= 2");
    end
    if (BLANK_CYC < 0 || BLANK_CYC >= TICK_DIV) begin : g_bad_blank
        $error("seg_scan_mux: BLANK_CYC must be 0..TICK_DIV-1");
    end

    logic            w_slot_last;
    logic            w_frame_first;
    state_t          w_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [2:0]      w_idx_nxt;
    logic            w_snap;
    logic            w_lit;
    logic            w_unused;
    logic [7:0][7:0] w_shadow_nxt;
    logic [7:0][7:0] r_shadow;
    logic [7:0]      r_seg;
    logic [7:0]      r_an;

    seg_scan_timer #(
        .DIGITS    (DIGITS),
        .TICK_DIV  (TICK_DIV),
        .BLANK_CYC (BLANK_CYC),
        .CW        (CW)
    ) u_timer (
        .clock         (clock),
        .reset         (reset),
        .i_en          (bus.en),
        .o_slot_last   (w_slot_last),
        .o_frame_first (w_frame_first),
        .o_state       (w_state),
        .o_cnt_nxt     (w_cnt_nxt),
        .o_idx_nxt     (w_idx_nxt),
        .o_state_nxt   (w_state_nxt)
    );

    assign w_unused     = ^{w_slot_last, w_state};
    assign w_snap       = bus.en && w_frame_first && !reset;
    assign w_shadow_nxt = w_snap ? bus.seg : r_shadow;

`ifdef SEG_SCAN_DIM_EN
    logic [2:0]  r_dim;
    logic [2:0]  w_dim_nxt;
    logic [31:0] w_ofs;

    assign w_dim_nxt = w_snap ? bus.dim : r_dim;
    assign w_ofs     = 32'(w_cnt_nxt) - 32'(BLANK_CYC);
    // Dimming shortens the lit part of SHOW; the tail of the slot stays dark.
    assign w_lit     = (w_state_nxt == SHOW) &&
                       (w_ofs < (32'(SHOW_LEN) >> w_dim_nxt));

    always_ff @(posedge clock) begin
        if (reset) r_dim <= '0;
        else       r_dim <= w_dim_nxt;
    end
`else
    logic [31:0] w_show_len_unused;
    assign w_show_len_unused = 32'(SHOW_LEN);
    assign w_lit = (w_state_nxt == SHOW);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_shadow <= {8{SEG_OFF}};
            r_seg    <= SEG_OFF;
            r_an     <= AN_OFF;
        end else begin
            r_shadow <= w_shadow_nxt;
            if (bus.en && w_lit) begin
                r_an  <= an_onehot_n(w_idx_nxt);
                r_seg <= w_shadow_nxt[w_idx_nxt];
            end else begin
                r_an  <= AN_OFF;
                r_seg <= SEG_OFF;
            end
        end
    end

    assign bus.scan_seg    = r_seg;
    assign bus.scan_an     = r_an;
    assign bus.frame_start = w_snap;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: directed scenarios, then random
// traffic against a frame-position reference model.
module tb_seg_scan_mux;

    localparam int TD    = 8;
    localparam int BC    = 2;
    localparam int ND    = 8;
    localparam int FRAME = ND * TD;

    logic clock = 1'b0;
    logic reset = 1'b1;

    seg_scan_if bus ();

    seg_scan_mux #(
        .DIGITS    (ND),
        .TICK_DIV  (TD),
        .BLANK_CYC (BC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic       en_v    = 1'b1;
    logic       rst_v   = 1'b1;
    int         dim_v   = 0;
    logic [7:0] seg_v[8];
    int         pos     = 0;
    int         mdim    = 0;
    int         cyc_n   = 0;
    logic [7:0] msh[8];
    int         lit_cnt[8];
    int         fs_cnt  = 0;
    int         base    = 0;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h at cycle %0d",
                   tag, obs, exp, cyc_n);
        end
    endtask

    task automatic clr_counts();
        for (int i = 0; i < 8; i++) lit_cnt[i] = 0;
        fs_cnt = 0;
    endtask

    // One clock cycle: drive inputs, check against the model, advance model.
    task automatic cyc();
        int         slot;
        int         c;
        logic       lit;
        logic [7:0] e_an;
        logic [7:0] e_seg;
        @(negedge clock);
        reset  = rst_v;
        bus.en = en_v;
        for (int i = 0; i < 8; i++) bus.seg[i] = seg_v[i];
`ifdef SEG_SCAN_DIM_EN
        bus.dim = 3'(dim_v);
`endif
        #1;
        cyc_n++;
        slot  = pos / TD;
        c     = pos % TD;
        lit   = (c >= BC) && ((c - BC) < ((TD - BC) >> mdim));
        e_an  = 8'hFF;
        e_seg = 8'hFF;
        if (lit) begin
            e_an[slot] = 1'b0;
            e_seg      = msh[slot];
        end
        chk("scan_an", bus.scan_an, e_an);
        chk("scan_seg", bus.scan_seg, e_seg);
        chk("frame_start", 8'(bus.frame_start),
            (!rst_v && en_v && pos == 0) ? 8'd1 : 8'd0);
        chk("one_anode", 8'($countones(~bus.scan_an) <= 1), 8'd1);
        for (int i = 0; i < 8; i++)
            if (bus.scan_an[i] == 1'b0) lit_cnt[i]++;
        if (bus.frame_start) fs_cnt++;
        if (rst_v) begin
            pos  = 0;
            mdim = 0;
            for (int i = 0; i < 8; i++) msh[i] = 8'hFF;
        end else if (!en_v) begin
            pos = 0;
        end else begin
            if (pos == 0) begin
                msh  = seg_v;
                mdim = dim_v;
            end
            pos = (pos + 1) % FRAME;
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            seg_v[i] = 8'(8'h10 + i);
            msh[i]   = 8'hFF;
            bus.seg[i] = seg_v[i];
        end
        bus.en = 1'b1;
`ifdef SEG_SCAN_DIM_EN
        bus.dim = 3'd0;
`endif
        reset = 1'b1;
        @(posedge clock);

        // Reset state
        rst_v = 1'b1;
        cyc();
        cyc();
        chk("reset_an", bus.scan_an, 8'hFF);
        chk("reset_seg", bus.scan_seg, 8'hFF);

        // Scenarios 1-3: first frames after reset release
        rst_v = 1'b0;
        cyc_n = -1;
        clr_counts();
        for (int k = 0; k < FRAME; k++) begin
            if (cyc_n + 1 == 20) seg_v[0] = 8'hC0;
            cyc();
            if (cyc_n == 0) chk("c0_fs", 8'(bus.frame_start), 8'd1);
            if (cyc_n == 1) chk("c1_an", bus.scan_an, 8'hFF);
            if (cyc_n == 2) chk("c2_an", bus.scan_an, 8'hFE);
            if (cyc_n == 7) chk("c7_seg", bus.scan_seg, 8'h10);
            if (cyc_n == 8) chk("c8_an", bus.scan_an, 8'hFF);
            if (cyc_n == 10) chk("c10_an", bus.scan_an, 8'hFD);
            if (cyc_n == 15) chk("c15_seg", bus.scan_seg, 8'h11);
        end
        for (int i = 0; i < ND; i++) chk("lit_cycles", 8'(lit_cnt[i]), 8'(TD - BC));
        chk("fs_per_frame", 8'(fs_cnt), 8'd1);

        clr_counts();
        while (cyc_n < 90) begin
            cyc();
            if (cyc_n == 64) chk("c64_fs", 8'(bus.frame_start), 8'd1);
            if (cyc_n == 65) chk("c65_an", bus.scan_an, 8'hFF);
            if (cyc_n == 66) chk("c66_seg", bus.scan_seg, 8'hC0);
        end

        // Scenario 4: en drop mid-SHOW of digit 3, restart later
        en_v = 1'b0;
        cyc();
        chk("drop_lit_an", bus.scan_an, 8'hF7);
        cyc();
        chk("drop_next_an", bus.scan_an, 8'hFF);
        chk("drop_next_seg", bus.scan_seg, 8'hFF);
        while (cyc_n < 103) cyc();
        en_v = 1'b1;
        cyc();
        chk("rise_fs", 8'(bus.frame_start), 8'd1);
        base = cyc_n;
        cyc();
        cyc();
        chk("rise_d0_an", bus.scan_an, 8'hFE);
        chk("rise_d0_seg", bus.scan_seg, 8'hC0);

        // Scenario 5: reset mid-slot of digit 1
        while (cyc_n < base + 12) cyc();
        rst_v = 1'b1;
        cyc();
        rst_v = 1'b0;
        cyc();
        chk("rst_an", bus.scan_an, 8'hFF);
        chk("rst_seg", bus.scan_seg, 8'hFF);
        chk("rst_fs", 8'(bus.frame_start), 8'd1);
        cyc();
        cyc();
        chk("rst_d0_an", bus.scan_an, 8'hFE);

`ifdef SEG_SCAN_DIM_EN
        // Scenario 6: dim=1 halves the lit window of each slot
        dim_v = 1;
        en_v  = 1'b0;
        cyc();
        en_v  = 1'b1;
        base  = cyc_n + 1;
        for (int k = 0; k < 2 * TD; k++) begin
            cyc();
            if (cyc_n == base + 4) chk("dim_c4_an", bus.scan_an, 8'hFE);
            if (cyc_n == base + 5) chk("dim_c5_an", bus.scan_an, 8'hFF);
            if (cyc_n == base + 7) chk("dim_c7_seg", bus.scan_seg, 8'hFF);
        end
        dim_v = 0;
`endif

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0)
                seg_v[$urandom_range(0, 7)] = 8'($urandom);
            if (en_v) en_v = ($urandom_range(0, 79) != 0);
            else      en_v = ($urandom_range(0, 3) == 0);
            rst_v = ($urandom_range(0, 399) == 0);
`ifdef SEG_SCAN_DIM_EN
            if ($urandom_range(0, 99) == 0) dim_v = $urandom_range(0, 7);
`endif
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
